// File: rtl/rhythm_pkg.sv
// Shared types and helpers for the rhythm-game datapath: tally state encoding,
// game-control keycodes and a saturating adder.
package rhythm_pkg;

  typedef enum logic [1:0] {
    TALLY_IDLE,
    TALLY_PLAY,
    TALLY_DONE
  } tally_state_t;

  localparam logic [7:0] KEY_START = 8'h2c;
  localparam logic [7:0] KEY_RESET = 8'h01;

  // Adds at 33 bits so the carry is never lost, then clamps to lim.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/score_tally_if.sv
// Bundle between the dropper array / keyboard (master) and the score tally
// (slave), carrying the per-drop flags in and the HUD values out.
interface score_tally_if #(
  parameter int NUM_DROPS = 32,
  parameter int SCORE_W   = 16,
  parameter int CNT_W     = 8
);
  logic [7:0]           keycode;
  logic [NUM_DROPS-1:0] score_vec;
  logic [NUM_DROPS-1:0] miss_vec;
  logic [SCORE_W-1:0]   total_score;
  logic [CNT_W-1:0]     hit_count;
  logic [CNT_W-1:0]     combo;
  logic [CNT_W-1:0]     max_combo;
  logic                 hit_pulse;
  logic                 game_done;

  modport master (
    output keycode, score_vec, miss_vec,
    input  total_score, hit_count, combo, max_combo, hit_pulse, game_done
  );

  modport slave (
    input  keycode, score_vec, miss_vec,
    output total_score, hit_count, combo, max_combo, hit_pulse, game_done
  );
endinterface

// File: rtl/score_tally_popcount.sv
// Combinational population count; the count is wide enough to hold WIDTH.
module popcount #(
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/score_tally.sv
// Game score tally: edge-detects the per-drop hit/miss levels, counts each drop
// at most once per game and sequences Idle -> Play -> Done.
module score_tally
  import rhythm_pkg::*;
#(
  parameter int NUM_DROPS   = 32,
  parameter int SCORE_W     = 16,
  parameter int CNT_W       = 8,
  parameter int PTS_PER_HIT = 10
) (
  input logic          frame_clk,
  input logic          Reset_n,
  score_tally_if.slave bus
);
  localparam int          PC_W      = $clog2(NUM_DROPS + 1);
  localparam logic [31:0] SCORE_MAX = 32'({SCORE_W{1'b1}});
  localparam logic [31:0] CNT_MAX   = 32'({CNT_W{1'b1}});

  tally_state_t         state;
  logic [NUM_DROPS-1:0] prev_score, prev_miss, resolved;
  logic [SCORE_W-1:0]   score_q;
  logic [CNT_W-1:0]     hits_q, combo_q, max_q;
  logic                 pulse_q, done_q;

  logic [NUM_DROPS-1:0] new_hit, new_miss, resolved_next;
  logic [PC_W-1:0]      n_hit;
  logic [SCORE_W-1:0]   score_next;
  logic [CNT_W-1:0]     hits_next, combo_next;

  // A hit on a drop masks a miss on the same drop in the same frame.
  assign new_hit       = bus.score_vec & ~prev_score & ~resolved;
  assign new_miss      = bus.miss_vec & ~prev_miss & ~resolved & ~new_hit;
  assign resolved_next = resolved | new_hit | new_miss;

  popcount #(.WIDTH(NUM_DROPS)) u_popcount (
    .bits  (new_hit),
    .count (n_hit)
  );

  always_comb begin
    score_next = SCORE_W'(sat_add(32'(score_q), 32'(n_hit) * 32'(PTS_PER_HIT), SCORE_MAX));
    hits_next  = CNT_W'(sat_add(32'(hits_q), 32'(n_hit), CNT_MAX));
    combo_next = (|new_miss) ? '0 : CNT_W'(sat_add(32'(combo_q), 32'(n_hit), CNT_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= TALLY_IDLE;
      prev_score <= '0;
      prev_miss  <= '0;
      resolved   <= '0;
      score_q    <= '0;
      hits_q     <= '0;
      combo_q    <= '0;
      max_q      <= '0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      prev_score <= bus.score_vec;
      prev_miss  <= bus.miss_vec;
      pulse_q    <= 1'b0;
      case (state)
        TALLY_IDLE: begin
          if (bus.keycode == KEY_START) begin
            state    <= TALLY_PLAY;
            score_q  <= '0;
            hits_q   <= '0;
            combo_q  <= '0;
            max_q    <= '0;
            resolved <= '0;
          end
        end
        TALLY_PLAY: begin
          score_q  <= score_next;
          hits_q   <= hits_next;
          combo_q  <= combo_next;
          max_q    <= (combo_next > max_q) ? combo_next : max_q;
          resolved <= resolved_next;
          pulse_q  <= (n_hit != '0);
          if (&resolved_next) begin
            state  <= TALLY_DONE;
            done_q <= 1'b1;
          end else if (bus.keycode == KEY_RESET) begin
            state <= TALLY_IDLE;
          end
        end
        TALLY_DONE: begin
          if (bus.keycode == KEY_RESET) begin
            state  <= TALLY_IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= TALLY_IDLE;
      endcase
    end
  end

  assign bus.total_score = score_q;
  assign bus.hit_count   = hits_q;
  assign bus.combo       = combo_q;
  assign bus.max_combo   = max_q;
  assign bus.hit_pulse   = pulse_q;
  assign bus.game_done   = done_q;
endmodule

// File: tb/tb_score_tally.sv
// Bench for score_tally: a bit-level reference model pushes expected outputs per
// frame into a scoreboard that is popped and compared after each edge.
module tb_score_tally;
  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  always #5 frame_clk = ~frame_clk;

  score_tally_if #(.NUM_DROPS(32), .SCORE_W(16), .CNT_W(8)) bus ();
  score_tally_if #(.NUM_DROPS(32), .SCORE_W(8),  .CNT_W(8)) sbus ();

  score_tally #(.NUM_DROPS(32), .SCORE_W(16), .CNT_W(8), .PTS_PER_HIT(10)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  score_tally #(.NUM_DROPS(32), .SCORE_W(8), .CNT_W(8), .PTS_PER_HIT(100)) dut_sat (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (sbus)
  );

  typedef struct {
    int score;
    int hits;
    int combo;
    int maxc;
    bit pulse;
    bit done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int          m_state;
  logic [31:0] m_ps, m_pm, m_res;
  int          m_score, m_hits, m_combo, m_max;
  bit          m_pulse, m_done;
  logic [31:0] sv, mv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ps = '0; m_pm = '0; m_res = '0;
    m_score = 0; m_hits = 0; m_combo = 0; m_max = 0;
    m_pulse = 0; m_done = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic [31:0] s, input logic [31:0] m);
    int          nh;
    bit          any_miss;
    logic [31:0] res_n;
    nh = 0; any_miss = 0; res_n = m_res;
    for (int i = 0; i < 32; i++) begin
      bit h;
      h = s[i] && !m_ps[i] && !m_res[i];
      if (h) begin nh++; res_n[i] = 1'b1; end
      if (m[i] && !m_pm[i] && !m_res[i] && !h) begin any_miss = 1; res_n[i] = 1'b1; end
    end
    m_pulse = 0;
    case (m_state)
      0: if (k == 8'h2c) begin
           m_state = 1; m_score = 0; m_hits = 0; m_combo = 0; m_max = 0; m_res = '0;
         end
      1: begin
           m_score = (m_score + nh * 10 > 65535) ? 65535 : m_score + nh * 10;
           m_hits  = (m_hits + nh > 255) ? 255 : m_hits + nh;
           m_combo = any_miss ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
           if (m_combo > m_max) m_max = m_combo;
           m_res   = res_n;
           m_pulse = (nh != 0);
           if (res_n == 32'hFFFF_FFFF) begin m_state = 2; m_done = 1; end
           else if (k == 8'h01) m_state = 0;
         end
      default: if (k == 8'h01) begin m_state = 0; m_done = 0; end
    endcase
    m_ps = s;
    m_pm = m;
  endtask

  task automatic cycle(input logic [7:0] k, input logic [31:0] s, input logic [31:0] m);
    exp_t e;
    bus.keycode = k; bus.score_vec = s; bus.miss_vec = m;
    model_step(k, s, m);
    sb.push_back('{m_score, m_hits, m_combo, m_max, m_pulse, m_done});
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    check("total_score", 32'(bus.total_score), e.score);
    check("hit_count",   32'(bus.hit_count),   e.hits);
    check("combo",       32'(bus.combo),       e.combo);
    check("max_combo",   32'(bus.max_combo),   e.maxc);
    check("hit_pulse",   32'(bus.hit_pulse),   32'(e.pulse));
    check("game_done",   32'(bus.game_done),   32'(e.done));
  endtask

  task automatic sat_cycle(input logic [7:0] k, input logic [31:0] s);
    sbus.keycode = k; sbus.score_vec = s; sbus.miss_vec = '0;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_score"}, 32'(bus.total_score), 0);
    check({tag, "_hits"},  32'(bus.hit_count),   0);
    check({tag, "_combo"}, 32'(bus.combo),       0);
    check({tag, "_max"},   32'(bus.max_combo),   0);
    check({tag, "_pulse"}, 32'(bus.hit_pulse),   0);
    check({tag, "_done"},  32'(bus.game_done),   0);
  endtask

  initial begin
    bus.keycode = '0;  bus.score_vec = '0;  bus.miss_vec = '0;
    sbus.keycode = '0; sbus.score_vec = '0; sbus.miss_vec = '0;
    sv = '0; mv = '0;
    model_reset();
    #12;
    check_zero("reset");
    Reset_n = 1'b1;
    @(posedge frame_clk);
    #1;

    // Start a game, then a single hit on drop 3.
    cycle(8'h2c, sv, mv);
    sv[3] = 1'b1;
    cycle(8'h00, sv, mv);
    check("first_hit_score", 32'(bus.total_score), 10);
    check("first_hit_pulse", 32'(bus.hit_pulse), 1);
    cycle(8'h00, sv, mv);
    check("pulse_one_cycle", 32'(bus.hit_pulse), 0);

    // Drop 3 toggles but stays counted once.
    sv[3] = 1'b0; cycle(8'h00, sv, mv);
    sv[3] = 1'b1; cycle(8'h00, sv, mv);
    check("toggle_once", 32'(bus.hit_count), 1);

    // Three hits in one frame, then a miss clears the combo.
    sv[2:0] = 3'b111; cycle(8'h00, sv, mv);
    check("triple_combo", 32'(bus.combo), 4);
    mv[5] = 1'b1; cycle(8'h00, sv, mv);
    check("miss_combo", 32'(bus.combo), 0);
    check("miss_max",   32'(bus.max_combo), 4);

    // Build combo 4, then hit and miss together on different drops.
    sv[13:10] = 4'hf; cycle(8'h00, sv, mv);
    sv[7] = 1'b1; mv[9] = 1'b1; cycle(8'h00, sv, mv);
    check("mixed_combo", 32'(bus.combo), 0);
    check("mixed_hits",  32'(bus.hit_count), 9);
    check("mixed_score", 32'(bus.total_score), 90);

    // Hit and miss rising on the same drop: the hit wins.
    sv[20] = 1'b1; mv[20] = 1'b1; cycle(8'h00, sv, mv);
    check("same_drop_hit", 32'(bus.hit_count), 10);

    // Resolve every remaining drop: misses on 28..31, hits elsewhere.
    sv = 32'h0FFF_FFFF; mv = mv | 32'hF000_0000;
    cycle(8'h00, sv, mv);
    check("all_resolved_done", 32'(bus.game_done), 1);
    sv = '0; mv = '0;
    cycle(8'h00, sv, mv);
    sv = 32'h0000_00FF;
    cycle(8'h00, sv, mv);
    cycle(8'h01, sv, mv);
    check("idle_done_clear", 32'(bus.game_done), 0);
    sv = '0;
    cycle(8'h00, sv, mv);
    cycle(8'h2c, sv, mv);
    check_zero("restart");

    // Leave Play early, confirm Idle ignores hits, then restart.
    sv[1] = 1'b1; cycle(8'h00, sv, mv);
    cycle(8'h01, sv, mv);
    sv[2] = 1'b1; cycle(8'h00, sv, mv);
    check("idle_no_count", 32'(bus.total_score), 10);
    cycle(8'h2c, sv, mv);
    sv[4] = 1'b1; cycle(8'h00, sv, mv);

    // Asynchronous reset in the middle of a frame.
    bus.score_vec = '0; bus.miss_vec = '0; bus.keycode = '0;
    sv = '0;
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset_n = 1'b1;
    cycle(8'h00, sv, mv);

    // Narrow-score instance: 100 points per hit saturates at 255.
    sat_cycle(8'h2c, 32'h0);
    sat_cycle(8'h00, 32'h1);
    check("sat_score_1", 32'(sbus.total_score), 100);
    sat_cycle(8'h00, 32'h3);
    check("sat_score_2", 32'(sbus.total_score), 200);
    sat_cycle(8'h00, 32'h7);
    check("sat_score_3", 32'(sbus.total_score), 255);
    sat_cycle(8'h00, 32'hF);
    check("sat_score_4", 32'(sbus.total_score), 255);
    check("sat_hits",    32'(sbus.hit_count), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
